// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Purpose:
//   Sequencing stage wrapped around an external combinational ALU. A request
//   is accepted over a valid/ready handshake, and its opcode, operands and
//   shift amount are registered. Those registers drive the ALU inputs and stay
//   stable while the ALU settles. DIV gets a multicycle settling window. Every
//   other opcode settles in a single cycle. The ALU result and flags are then
//   captured, together with a locally computed carry/borrow and the divide-by-
//   zero and illegal-opcode indications. The result is presented downstream
//   over a second valid/ready handshake.
//
// Ports:
//   clk         in   1      clock, all state on rising edge
//   rst_n       in   1      asynchronous active-low reset
//   reqValid    in   1      request valid
//   reqReady    out  1      stage can accept a request this cycle
//   reqOpcode   in   OPW    operation code
//   reqA        in   WIDTH  operand 1
//   reqB        in   WIDTH  operand 2
//   reqShift    in   SHW    shift amount
//   aluOpcode   out  OPW    registered opcode to ALU
//   aluInput1   out  WIDTH  registered operand 1 to ALU
//   aluInput2   out  WIDTH  registered operand 2 to ALU
//   aluShift    out  SHW    registered shift amount to ALU
//   aluResult   in   WIDTH  ALU result
//   aluZero     in   1      ALU zero flag
//   aluSign     in   1      ALU sign flag
//   rspValid    out  1      response valid
//   rspReady    in   1      downstream accepts response
//   rspResult   out  WIDTH  captured result
//   rspZero     out  1      captured zero flag
//   rspSign     out  1      captured sign flag
//   rspCarry    out  1      carry (ADD) / borrow (SUB), 0 otherwise
//   rspDivZero  out  1      DIV with operand 2 equal to zero
//   rspIllegal  out  1      opcode above DIV_OP
//   opsDone     out  CNTW   count of completed response handshakes (wraps)
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WIDTH      = 64,
  parameter int OPW        = 4,
  parameter int SHW        = 5,
  parameter int DIV_OP     = 7,
  parameter int DIV_CYCLES = 8,
  parameter int CNTW       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [OPW-1:0]   reqOpcode,
  input  logic [WIDTH-1:0] reqA,
  input  logic [WIDTH-1:0] reqB,
  input  logic [SHW-1:0]   reqShift,
  output logic [OPW-1:0]   aluOpcode,
  output logic [WIDTH-1:0] aluInput1,
  output logic [WIDTH-1:0] aluInput2,
  output logic [SHW-1:0]   aluShift,
  input  logic [WIDTH-1:0] aluResult,
  input  logic             aluZero,
  input  logic             aluSign,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspResult,
  output logic             rspZero,
  output logic             rspSign,
  output logic             rspCarry,
  output logic             rspDivZero,
  output logic             rspIllegal,
  output logic [CNTW-1:0]  opsDone
);

  // A single-cycle DIV window still needs a one-bit counter.
  localparam int HCW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(DIV_OP);
  localparam logic [HCW-1:0] HOLD_DIV = HCW'(DIV_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_0   = {HCW{1'b0}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Carry out of an unsigned ADD, or borrow of an unsigned SUB.
  function automatic logic f_carry(input logic [OPW-1:0]   op,
                                   input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    logic           res;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  res = sum[WIDTH];
      OP_SUB:  res = (a < b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [HCW-1:0]   r_hold_cnt;
  logic [OPW-1:0]   r_alu_opcode;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SHW-1:0]   r_alu_shift;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_sign;
  logic             r_rsp_carry;
  logic             r_rsp_divzero;
  logic             r_rsp_illegal;
  logic [CNTW-1:0]  r_ops_done;

  logic             w_rsp_hs;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_capture;

  // Handshake strobes and next-state decode.
  // A response handshake in RESP reopens the request port in the same cycle,
  // so back-to-back operations go RESP -> EXEC without an idle bubble.
  always_comb begin
    w_rsp_hs    = (r_state == S_RESP) && rspReady;
    w_req_ready = (r_state == S_IDLE) || w_rsp_hs;
    w_accept    = reqValid && w_req_ready;
    w_capture   = (r_state == S_EXEC) && (r_hold_cnt == HOLD_0);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_capture) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_RESP: begin
        if (w_accept) begin
          w_state_nxt = S_EXEC;
        end else if (w_rsp_hs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; rspValid is registered and tracks the RESP state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= (w_state_nxt == S_RESP);
    end
  end

  // ALU input registers: loaded on accept, otherwise hold their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_opcode <= {OPW{1'b0}};
      r_alu_a      <= {WIDTH{1'b0}};
      r_alu_b      <= {WIDTH{1'b0}};
      r_alu_shift  <= {SHW{1'b0}};
    end else if (w_accept) begin
      r_alu_opcode <= reqOpcode;
      r_alu_a      <= reqA;
      r_alu_b      <= reqB;
      r_alu_shift  <= reqShift;
    end
  end

  // Settling counter. A DIV stays in EXEC for DIV_CYCLES cycles. Every other
  // opcode stays in EXEC for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= HOLD_0;
    end else if (w_accept) begin
      r_hold_cnt <= (reqOpcode == OP_DIV) ? HOLD_DIV : HOLD_0;
    end else if ((r_state == S_EXEC) && (r_hold_cnt != HOLD_0)) begin
      r_hold_cnt <= r_hold_cnt - HCW'(1);
    end
  end

  // Response capture at the end of the settling window; stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result  <= {WIDTH{1'b0}};
      r_rsp_zero    <= 1'b0;
      r_rsp_sign    <= 1'b0;
      r_rsp_carry   <= 1'b0;
      r_rsp_divzero <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else if (w_capture) begin
      r_rsp_result  <= aluResult;
      r_rsp_zero    <= aluZero;
      r_rsp_sign    <= aluSign;
      r_rsp_carry   <= f_carry(r_alu_opcode, r_alu_a, r_alu_b);
      r_rsp_divzero <= (r_alu_opcode == OP_DIV) && (r_alu_b == {WIDTH{1'b0}});
      r_rsp_illegal <= (r_alu_opcode > OP_DIV);
    end
  end

  // Completed-operation counter; wraps naturally at 2^CNTW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops_done <= {CNTW{1'b0}};
    end else if (w_rsp_hs) begin
      r_ops_done <= r_ops_done + CNTW'(1);
    end
  end

  assign reqReady   = w_req_ready;
  assign aluOpcode  = r_alu_opcode;
  assign aluInput1  = r_alu_a;
  assign aluInput2  = r_alu_b;
  assign aluShift   = r_alu_shift;
  assign rspValid   = r_rsp_valid;
  assign rspResult  = r_rsp_result;
  assign rspZero    = r_rsp_zero;
  assign rspSign    = r_rsp_sign;
  assign rspCarry   = r_rsp_carry;
  assign rspDivZero = r_rsp_divzero;
  assign rspIllegal = r_rsp_illegal;
  assign opsDone    = r_ops_done;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam int WIDTH = 64;
  localparam int OPW   = 4;
  localparam int SHW   = 5;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             reqValid;
  logic             reqReady;
  logic [OPW-1:0]   reqOpcode;
  logic [WIDTH-1:0] reqA;
  logic [WIDTH-1:0] reqB;
  logic [SHW-1:0]   reqShift;
  logic [OPW-1:0]   aluOpcode;
  logic [WIDTH-1:0] aluInput1;
  logic [WIDTH-1:0] aluInput2;
  logic [SHW-1:0]   aluShift;
  logic [WIDTH-1:0] aluResult;
  logic             aluZero;
  logic             aluSign;
  logic             rspValid;
  logic             rspReady;
  logic [WIDTH-1:0] rspResult;
  logic             rspZero;
  logic             rspSign;
  logic             rspCarry;
  logic             rspDivZero;
  logic             rspIllegal;
  logic [CNTW-1:0]  opsDone;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;

  // Logic-op vectors: opcode, A, B, shift, result, {zero,sign,carry,divzero,illegal}
  localparam logic [3:0]  T_OP [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd2};
  localparam logic [63:0] T_A  [6] = '{64'hF0F0, 64'h0F, 64'h0000_0001_0000_0003,
                                       64'h0, 64'd123, 64'hF0};
  localparam logic [63:0] T_B  [6] = '{64'hFF00, 64'hF0, 64'h0, 64'h0,
                                       64'h8000_0000_0000_0000, 64'h0F};
  localparam logic [4:0]  T_SH [6] = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0};
  localparam logic [63:0] T_R  [6] = '{64'hF000, 64'hFF, 64'h0000_0010_0000_0030,
                                       64'hFFFF_FFFF_FFFF_FFFF,
                                       64'h8000_0000_0000_0000, 64'h0};
  localparam logic [4:0]  T_F  [6] = '{5'b00000, 5'b00000, 5'b00000,
                                       5'b01000, 5'b01000, 5'b10000};

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqOpcode  (reqOpcode),
    .reqA       (reqA),
    .reqB       (reqB),
    .reqShift   (reqShift),
    .aluOpcode  (aluOpcode),
    .aluInput1  (aluInput1),
    .aluInput2  (aluInput2),
    .aluShift   (aluShift),
    .aluResult  (aluResult),
    .aluZero    (aluZero),
    .aluSign    (aluSign),
    .rspValid   (rspValid),
    .rspReady   (rspReady),
    .rspResult  (rspResult),
    .rspZero    (rspZero),
    .rspSign    (rspSign),
    .rspCarry   (rspCarry),
    .rspDivZero (rspDivZero),
    .rspIllegal (rspIllegal),
    .opsDone    (opsDone)
  );

  // Combinational ALU sitting behind the stage
  always_comb begin
    aluResult = 64'd0;
    case (aluOpcode)
      4'd0:    aluResult = aluInput1 + aluInput2;
      4'd1:    aluResult = aluInput1 - aluInput2;
      4'd2:    aluResult = aluInput1 & aluInput2;
      4'd3:    aluResult = aluInput1 | aluInput2;
      4'd4:    aluResult = aluInput1 << aluShift;
      4'd5:    aluResult = ~(aluInput1 ^ aluInput2);
      4'd6:    aluResult = aluInput2;
      4'd7:    aluResult = (aluInput2 == 64'd0) ? 64'd0 : aluInput1 / aluInput2;
      default: aluResult = 64'd0;
    endcase
    aluZero = (aluResult == 64'd0);
    aluSign = aluResult[63];
  end

  function automatic logic [4:0] flags();
    return {rspZero, rspSign, rspCarry, rspDivZero, rspIllegal};
  endfunction

  // Present a request at a falling edge and hold it until accepted.
  task automatic send(input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] sh);
    int guard;
    reqValid = 1'b1; reqOpcode = op; reqA = a; reqB = b; reqShift = sh;
    guard = 0;
    while (!reqReady && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  // Count falling edges after the accepting edge until rspValid (bounded).
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rspValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    exp_ops = exp_ops + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reqValid = 1'b0; rspReady = 1'b0;
    reqOpcode = 4'd0; reqA = 64'd0; reqB = 64'd0; reqShift = 5'd0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({reqReady, rspValid} !== 2'b10) begin
      errors++; $display("FAIL reset_handshake: got %b expected 10", {reqReady, rspValid});
    end
    checks++;
    if ({aluOpcode, aluInput1, aluInput2, aluShift} !== 137'd0) begin
      errors++; $display("FAIL reset_alu_regs: got %h %h %h %h expected all 0",
                         aluOpcode, aluInput1, aluInput2, aluShift);
    end
    checks++;
    if ({rspResult, flags(), opsDone} !== 73'd0) begin
      errors++; $display("FAIL reset_rsp: got %h %b %h expected all 0", rspResult, flags(), opsDone);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_carry();
    int lat;
    send(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0);
    wait_rsp(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
    checks++;
    if (rspResult !== 64'd0) begin
      errors++; $display("FAIL add_result: got %h expected 0", rspResult);
    end
    checks++;
    if (flags() !== 5'b10100) begin
      errors++; $display("FAIL add_flags: got %b expected 10100", flags());
    end
    ack();
    checks++;
    if ({rspValid, reqReady, opsDone} !== {2'b01, 4'd1}) begin
      errors++; $display("FAIL add_handshake: got %b %h expected 01 1", {rspValid, reqReady}, opsDone);
    end
  endtask

  task automatic test_sub_borrow();
    int lat;
    send(4'd1, 64'd3, 64'd5, 5'd0);
    wait_rsp(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sub_latency: got %0d expected 2", lat); end
    checks++;
    if (rspResult !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++; $display("FAIL sub_result: got %h expected fffffffffffffffe", rspResult);
    end
    checks++;
    if (flags() !== 5'b01100) begin
      errors++; $display("FAIL sub_flags: got %b expected 01100", flags());
    end
    ack();
  endtask

  task automatic test_logic_ops();
    int lat;
    for (int i = 0; i < 6; i++) begin
      send(T_OP[i], T_A[i], T_B[i], T_SH[i]);
      wait_rsp(lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL logic_latency[%0d]: got %0d expected 2", i, lat); end
      checks++;
      if (rspResult !== T_R[i]) begin
        errors++; $display("FAIL logic_result[%0d]: got %h expected %h", i, rspResult, T_R[i]);
      end
      checks++;
      if (flags() !== T_F[i]) begin
        errors++; $display("FAIL logic_flags[%0d]: got %b expected %b", i, flags(), T_F[i]);
      end
      ack();
    end
    checks++;
    if (opsDone !== 4'(exp_ops)) begin
      errors++; $display("FAIL logic_opsdone: got %0d expected %0d", opsDone, exp_ops);
    end
  endtask

  task automatic test_div();
    send(4'd7, 64'd100, 64'd7, 5'd0);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if ({rspValid, reqReady} !== 2'b00) begin
        errors++; $display("FAIL div_window_hs[%0d]: got %b expected 00", i, {rspValid, reqReady});
      end
      checks++;
      if ({aluOpcode, aluInput1, aluInput2} !== {4'd7, 64'd100, 64'd7}) begin
        errors++; $display("FAIL div_window_alu[%0d]: got %h %h %h expected 7 64 7",
                           i, aluOpcode, aluInput1, aluInput2);
      end
      @(negedge clk);
    end
    checks++;
    if (rspValid !== 1'b1) begin errors++; $display("FAIL div_valid_cycle9: got %b expected 1", rspValid); end
    checks++;
    if (rspResult !== 64'd14) begin errors++; $display("FAIL div_result: got %0d expected 14", rspResult); end
    checks++;
    if (flags() !== 5'b00000) begin errors++; $display("FAIL div_flags: got %b expected 00000", flags()); end
    ack();
  endtask

  task automatic test_div_zero_illegal();
    int lat;
    send(4'd7, 64'd5, 64'd0, 5'd0);
    wait_rsp(lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL divzero_latency: got %0d expected 9", lat); end
    checks++;
    if ({rspResult, flags()} !== {64'd0, 5'b10010}) begin
      errors++; $display("FAIL divzero_rsp: got %h %b expected 0 10010", rspResult, flags());
    end
    ack();
    send(4'd9, 64'd20, 64'd3, 5'd0);
    wait_rsp(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL illegal_latency: got %0d expected 2", lat); end
    checks++;
    if ({rspResult, flags()} !== {64'd0, 5'b10001}) begin
      errors++; $display("FAIL illegal_rsp: got %h %b expected 0 10001", rspResult, flags());
    end
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    send(4'd0, 64'd7, 64'd8, 5'd0);
    wait_rsp(lat);
    reqValid = 1'b1; reqOpcode = 4'd1; reqA = 64'd10; reqB = 64'd4; reqShift = 5'd0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rspValid, reqReady, rspResult} !== {2'b10, 64'd15}) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b %0d expected 10 15", i, {rspValid, reqReady}, rspResult);
      end
      @(negedge clk);
    end
    rspReady = 1'b1;
    #1;
    checks++;
    if (reqReady !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b expected 1", reqReady); end
    @(negedge clk);
    reqValid = 1'b0; rspReady = 1'b0;
    exp_ops = exp_ops + 1;
    checks++;
    if ({rspValid, aluOpcode, aluInput1, aluInput2} !== {1'b0, 4'd1, 64'd10, 64'd4}) begin
      errors++; $display("FAIL bp_no_bubble: got %b %h %0d %0d expected 0 1 10 4",
                         rspValid, aluOpcode, aluInput1, aluInput2);
    end
    checks++;
    if (opsDone !== 4'(exp_ops)) begin
      errors++; $display("FAIL bp_opsdone: got %0d expected %0d", opsDone, exp_ops);
    end
    @(negedge clk);
    checks++;
    if ({rspValid, rspResult, flags()} !== {1'b1, 64'd6, 5'b00000}) begin
      errors++; $display("FAIL bp_second_rsp: got %b %0d %b expected 1 6 00000", rspValid, rspResult, flags());
    end
    ack();
  endtask

  task automatic test_reset_mid_div();
    int lat;
    send(4'd7, 64'd100, 64'd7, 5'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({reqReady, rspValid} !== 2'b10) begin
      errors++; $display("FAIL rstdiv_handshake: got %b expected 10", {reqReady, rspValid});
    end
    checks++;
    if ({aluOpcode, aluInput1, aluInput2, rspResult, flags(), opsDone} !== 205'd0) begin
      errors++; $display("FAIL rstdiv_clear: got %h %h %h %h %b %h expected all 0",
                         aluOpcode, aluInput1, aluInput2, rspResult, flags(), opsDone);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    @(negedge clk);
    send(4'd0, 64'd2, 64'd2, 5'd0);
    wait_rsp(lat);
    checks++;
    if ({lat[3:0], rspResult, flags()} !== {4'd2, 64'd4, 5'b00000}) begin
      errors++; $display("FAIL rstdiv_add: got lat %0d %0d %b expected lat 2 4 00000", lat, rspResult, flags());
    end
    ack();
  endtask

  task automatic test_back_to_back();
    reqValid = 1'b1; reqOpcode = 4'd6; reqA = 64'd0; reqB = 64'd100; reqShift = 5'd0;
    rspReady = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if ({rspValid, opsDone} !== {1'b0, 4'(exp_ops + i)}) begin
        errors++; $display("FAIL b2b_exec[%0d]: got %b %0d expected 0 %0d", i, rspValid, opsDone, 4'(exp_ops + i));
      end
      @(negedge clk);
      checks++;
      if ({rspValid, reqReady, rspResult} !== {2'b11, 64'(100 + i)}) begin
        errors++; $display("FAIL b2b_resp[%0d]: got %b %0d expected 11 %0d", i, {rspValid, reqReady}, rspResult, 100 + i);
      end
      if (i < 14) begin
        reqB = 64'(101 + i);
      end else begin
        reqValid = 1'b0;
      end
    end
    @(negedge clk);
    rspReady = 1'b0;
    exp_ops = exp_ops + 15;
    checks++;
    if ({rspValid, reqReady, opsDone} !== {2'b01, 4'd0}) begin
      errors++; $display("FAIL b2b_wrap: got %b %0d expected 01 0", {rspValid, reqReady}, opsDone);
    end
    checks++;
    if (aluInput2 !== 64'd114) begin
      errors++; $display("FAIL b2b_alu_keep: got %0d expected 114", aluInput2);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_logic_ops();
    test_div();
    test_div_zero_illegal();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1);
  end

endmodule
